// File: rtl/pmem_arbiter_pkg.sv
// Purpose: shared LC-3b memory types plus the pmem arbiter state encoding.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package pmem_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_block;

    // Arbiter FSM states, exported so benches can compare against them.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } pmem_arb_state_t;

    // Which cache owned the most recent grant (round-robin pointer).
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } pmem_arb_owner_t;

    // One line is 16 bytes, so the low nibble of a line address is always zero.
    localparam lc3b_word LINE_MASK = 16'hFFF0;

    function automatic lc3b_word line_align(input lc3b_word addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Purpose: bundles both cache line ports and the physical-memory port.
// Latency: n/a (wires only).
// Backpressure: level requests held by each cache until its own resp pulse.
// Ports: icache_* / dcache_* cache side, pmem_* physical-memory side.
//   slave  = arbiter view (requests in, memory strobes out).
//   master = environment view (caches and memory model).
interface pmem_arbiter_if;
    import pmem_arbiter_pkg::*;

    logic        icache_pmem_read;
    lc3b_word    icache_pmem_address;
    lc3b_c_block icache_pmem_rdata;
    logic        icache_pmem_resp;

    logic        dcache_pmem_read;
    logic        dcache_pmem_write;
    lc3b_word    dcache_pmem_address;
    lc3b_c_block dcache_pmem_wdata;
    lc3b_c_block dcache_pmem_rdata;
    logic        dcache_pmem_resp;

    logic        pmem_read;
    logic        pmem_write;
    lc3b_word    pmem_address;
    lc3b_c_block pmem_wdata;
    lc3b_c_block pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  icache_pmem_read, icache_pmem_address,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output icache_pmem_read, icache_pmem_address,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pmem_arbiter_sat_counter.sv
// Purpose: saturating up-counter for contention statistics.
// Latency: count reflects inc one cycle later.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), inc, count.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [width-1:0] count
);

    localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] count_q;
    logic [width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {width{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Purpose: round-robin share of one physical-memory port between icache and dcache.
// Latency: grant registered (request in IDLE -> strobe next cycle); resp/rdata combinational.
// Backpressure: loser waits with request held; one IDLE cycle between every transaction.
// Ports: clk, rst_n, bus (pmem_arbiter_if.slave), icache/dcache_wait_count (saturating).
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pmem_arbiter_if.slave        bus,
    output logic [CNT_WIDTH-1:0] icache_wait_count,
    output logic [CNT_WIDTH-1:0] dcache_wait_count
);

    pmem_arb_state_t state_q, state_d;
    pmem_arb_owner_t last_grant_q, last_grant_d;
    lc3b_word        addr_q, addr_d;
    lc3b_c_block     wdata_q, wdata_d;
    logic            write_q, write_d;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic busy;

    assign i_req = bus.icache_pmem_read;
    assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;
    assign busy  = (state_q == I_BUSY) || (state_q == D_BUSY);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the cache that did not win last time goes first.
                if (d_req && (!i_req || (last_grant_q == GRANT_I))) begin
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end
            end
            I_BUSY, D_BUSY: begin
                // Always return to IDLE so the strobes drop between transactions.
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_d) begin
            state_d      = D_BUSY;
            last_grant_d = GRANT_D;
            addr_d       = line_align(bus.dcache_pmem_address);
            wdata_d      = bus.dcache_pmem_wdata;
            // Read and write together is a write-back.
            write_d      = bus.dcache_pmem_write;
        end else if (grant_i) begin
            state_d      = I_BUSY;
            last_grant_d = GRANT_I;
            addr_d       = line_align(bus.icache_pmem_address);
            write_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
        end
    end

    // Memory side: strobes only while BUSY, from the op latched at grant.
    assign bus.pmem_read    = busy & ~write_q;
    assign bus.pmem_write   = busy & write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    // Return path steered to the owner only; the idle side sees zeros.
    assign bus.icache_pmem_resp  = (state_q == I_BUSY) & bus.pmem_resp;
    assign bus.dcache_pmem_resp  = (state_q == D_BUSY) & bus.pmem_resp;
    assign bus.icache_pmem_rdata = (state_q == I_BUSY) ? bus.pmem_rdata : '0;
    assign bus.dcache_pmem_rdata = (state_q == D_BUSY) ? bus.pmem_rdata : '0;

    // A requester is waiting whenever it asks and is not the current owner,
    // including the IDLE cycle in which it is being granted.
    sat_counter #(.width(CNT_WIDTH)) u_icache_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_req && (state_q != I_BUSY)),
        .count (icache_wait_count)
    );

    sat_counter #(.width(CNT_WIDTH)) u_dcache_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (d_req && (state_q != D_BUSY)),
        .count (dcache_wait_count)
    );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Purpose: directed stimulus with a grant/response scoreboard for pmem_arbiter.
// Latency: memory model answers on the mem_lat-th strobe cycle.
// Backpressure: cache models hold each request until its resp is seen.
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmem_arbiter_if bus ();
    pmem_arbiter_if bus2 ();

    logic [15:0] i_cnt, d_cnt;
    logic [3:0]  i_cnt2, d_cnt2;

    pmem_arbiter #(.CNT_WIDTH(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus.slave),
        .icache_wait_count (i_cnt),
        .dcache_wait_count (d_cnt)
    );

    pmem_arbiter #(.CNT_WIDTH(4)) dut_sat (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus2.slave),
        .icache_wait_count (i_cnt2),
        .dcache_wait_count (d_cnt2)
    );

    int checks = 0;
    int errors = 0;

    // Outstanding requests = issued - served; each cache keeps its level high meanwhile.
    int   i_issue = 0, i_served = 0, d_issue = 0, d_served = 0;
    logic d_is_write = 1'b0;
    int   mem_lat = 0;
    int   scnt = 0;

    assign bus.icache_pmem_read  = (i_issue != i_served);
    assign bus.dcache_pmem_read  = (d_issue != d_served) && !d_is_write;
    assign bus.dcache_pmem_write = (d_issue != d_served) && d_is_write;

    typedef struct {
        logic        is_d;
        logic        write;
        logic [15:0] addr;
        logic [127:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    logic active = 1'b0;
    logic prev_strobe = 1'b0;
    logic mon_strobe;

    function automatic logic [127:0] rdata_of(input logic [15:0] a);
        return {32'hDEAD_BEEF, 32'h0123_4567, 48'h0, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory model: pulse resp on the mem_lat-th consecutive strobe cycle.
    always @(posedge clk) begin
        #1;
        if (bus.pmem_read || bus.pmem_write) scnt = scnt + 1;
        else scnt = 0;
        if ((mem_lat != 0) && (scnt == mem_lat)) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = rdata_of(bus.pmem_address);
        end else begin
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = '0;
        end
    end

    // Scoreboard monitor: pops an expected transaction at every grant and
    // checks strobes, address, data stability and response routing.
    always @(negedge clk) begin
        if (!rst_n) begin
            active      = 1'b0;
            prev_strobe = 1'b0;
        end else begin
            mon_strobe = bus.pmem_read | bus.pmem_write;
            if (mon_strobe && !prev_strobe) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 1'b1, 1'b0);
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    chk("grant_write", bus.pmem_write, cur.write);
                    chk("grant_read", bus.pmem_read, !cur.write);
                    chk("grant_addr", bus.pmem_address, cur.addr);
                    if (cur.write) chk("grant_wdata", bus.pmem_wdata, cur.wdata);
                end
            end else if (mon_strobe && active) begin
                chk("hold_addr", bus.pmem_address, cur.addr);
                if (cur.write) chk("hold_wdata", bus.pmem_wdata, cur.wdata);
            end
            if (bus.icache_pmem_resp || bus.dcache_pmem_resp) begin
                if (!active) begin
                    chk("stray_resp", 1'b1, 1'b0);
                end else begin
                    chk("resp_route", {bus.icache_pmem_resp, bus.dcache_pmem_resp},
                        cur.is_d ? 2'b01 : 2'b10);
                    chk("resp_rdata", cur.is_d ? bus.dcache_pmem_rdata : bus.icache_pmem_rdata,
                        rdata_of(cur.addr));
                    if (cur.is_d) d_served = d_served + 1;
                    else i_served = i_served + 1;
                    active = 1'b0;
                end
            end
            prev_strobe = mon_strobe;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue_i(input logic [15:0] a);
        txn_t t;
        t.is_d = 1'b0; t.write = 1'b0; t.addr = a & 16'hFFF0; t.wdata = '0;
        bus.icache_pmem_address = a;
        exp_q.push_back(t);
        i_issue = i_issue + 1;
    endtask

    task automatic issue_d(input logic wr, input logic [15:0] a, input logic [127:0] wd);
        txn_t t;
        t.is_d = 1'b1; t.write = wr; t.addr = a & 16'hFFF0; t.wdata = wd;
        bus.dcache_pmem_address = a;
        bus.dcache_pmem_wdata   = wd;
        d_is_write = wr;
        exp_q.push_back(t);
        d_issue = d_issue + 1;
    endtask

    task automatic wait_served(input string name);
        int n;
        n = 0;
        while (((i_issue != i_served) || (d_issue != d_served)) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 300), 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.icache_pmem_address  = '0;
        bus.dcache_pmem_address  = '0;
        bus.dcache_pmem_wdata    = '0;
        bus2.icache_pmem_read    = 1'b0;
        bus2.icache_pmem_address = '0;
        bus2.dcache_pmem_read    = 1'b0;
        bus2.dcache_pmem_write   = 1'b0;
        bus2.dcache_pmem_address = '0;
        bus2.dcache_pmem_wdata   = '0;
        bus2.pmem_rdata          = '0;
        bus2.pmem_resp           = 1'b0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", dut.state_q, IDLE);
        chk("rst_pmem_read", bus.pmem_read, 1'b0);
        chk("rst_pmem_write", bus.pmem_write, 1'b0);
        chk("rst_pmem_address", bus.pmem_address, 16'h0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 128'h0);
        chk("rst_resps", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
        chk("rst_i_rdata", bus.icache_pmem_rdata, 128'h0);
        chk("rst_d_rdata", bus.dcache_pmem_rdata, 128'h0);
        chk("rst_counts", {i_cnt, d_cnt}, 32'h0);
        rst_n = 1'b1;

        // Reset in the middle of an icache fill
        @(posedge clk); #1;
        mem_lat = 0;
        issue_i(16'h4448);
        repeat (3) @(negedge clk);
        chk("midrst_pre_read", bus.pmem_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_read", bus.pmem_read, 1'b0);
        chk("midrst_state", dut.state_q, IDLE);
        chk("midrst_counts", {i_cnt, d_cnt}, 32'h0);
        chk("midrst_resp", bus.icache_pmem_resp, 1'b0);
        i_issue = i_served;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lone icache fill, memory answers on cycle 5
        do_reset();
        @(posedge clk); #1;
        mem_lat = 5;
        issue_i(16'h1236);
        @(negedge clk);
        chk("lone_c0_read", bus.pmem_read, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("lone_read", bus.pmem_read, (k <= 5));
            chk("lone_i_resp", bus.icache_pmem_resp, (k == 5));
            chk("lone_d_resp", bus.dcache_pmem_resp, 1'b0);
            if (k == 5) chk("lone_rdata", bus.icache_pmem_rdata, rdata_of(16'h1230));
        end
        wait_served("lone_timeout");
        chk("lone_i_cnt", i_cnt, 16'd1);
        chk("lone_d_cnt", d_cnt, 16'd0);

        // Simultaneous first requests; dcache inputs change mid-transaction
        do_reset();
        @(posedge clk); #1;
        mem_lat = 4;
        issue_d(1'b1, 16'h2000, {16{8'hA5}});
        issue_i(16'h0100);
        repeat (3) @(negedge clk);
        bus.dcache_pmem_address = 16'h7777;
        bus.dcache_pmem_wdata   = '1;
        wait_served("simul_timeout");
        chk("simul_i_cnt", i_cnt, 16'd6);
        chk("simul_d_cnt", d_cnt, 16'd1);

        // Round robin with both caches requesting back to back: D, I, D, I
        do_reset();
        @(posedge clk); #1;
        mem_lat = 3;
        issue_d(1'b0, 16'h5008, '0);
        issue_i(16'h600F);
        issue_d(1'b0, 16'h5008, '0);
        issue_i(16'h600F);
        wait_served("rr_timeout");
        chk("rr_i_cnt", i_cnt, 16'd10);
        chk("rr_d_cnt", d_cnt, 16'd6);

        // Saturation on the 4-bit instance: dcache holds the port forever
        do_reset();
        @(posedge clk); #1;
        bus2.dcache_pmem_write   = 1'b1;
        bus2.dcache_pmem_address = 16'h3000;
        bus2.icache_pmem_read    = 1'b1;
        bus2.icache_pmem_address = 16'h0040;
        @(negedge clk);
        chk("sat_c0", i_cnt2, 4'd0);
        repeat (5) @(negedge clk);
        chk("sat_c5", i_cnt2, 4'd5);
        repeat (15) @(negedge clk);
        chk("sat_c20", i_cnt2, 4'd15);
        repeat (5) @(negedge clk);
        chk("sat_c25", i_cnt2, 4'd15);
        chk("sat_d_cnt", d_cnt2, 4'd1);
        chk("sat_owner_write", bus2.pmem_write, 1'b1);
        bus2.dcache_pmem_write = 1'b0;
        bus2.icache_pmem_read  = 1'b0;

        repeat (3) @(negedge clk);
        chk("leftover_txn", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Shares the single physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core. Each cache's line-fill/write-back port (one 128-bit line per transaction) sits on one side, physical memory on the other. A registered round-robin FSM grants one cache at a time, latches its request, and routes `pmem_resp` and `pmem_rdata` back to that cache only. Saturating wait counters expose contention for performance debug.

## Interface
- `CNT_WIDTH`, default 16: width of each wait counter.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `icache_pmem_read`  in  1: icache line-fill request, level, held until its resp.
- `icache_pmem_address`  in  16 (`lc3b_word`): icache line address.
- `icache_pmem_rdata`  out  128 (`lc3b_c_block`): fill data to icache.
- `icache_pmem_resp`  out  1: icache transaction complete.
- `dcache_pmem_read`  in  1: dcache line-fill request, level.
- `dcache_pmem_write`  in  1: dcache write-back request, level.
- `dcache_pmem_address`  in  16: dcache line address.
- `dcache_pmem_wdata`  in  128: dcache write-back line.
- `dcache_pmem_rdata`  out  128: fill data to dcache.
- `dcache_pmem_resp`  out  1: dcache transaction complete.
- `pmem_read`, `pmem_write`  out  1 each: physical memory strobes, level.
- `pmem_address`  out  16: latched line address, bits [3:0] forced to 0.
- `pmem_wdata`  out  128: latched write line.
- `pmem_rdata`  in  128; `pmem_resp`  in  1: physical memory return.
- `icache_wait_count`, `dcache_wait_count`  out  `CNT_WIDTH`: saturating count of cycles each requester spent waiting for a grant.

## Operation
- States: IDLE, I_BUSY, D_BUSY. Reset state is IDLE. Reset `last_grant` is I, so dcache wins the first tie.
- IDLE:
  - Only icache requesting: go to I_BUSY.
  - Only dcache requesting (read or write): go to D_BUSY.
  - Both requesting: grant the requester that is not `last_grant`.
  - On entering a BUSY state, latch address, wdata and op (read/write), and set `last_grant`.
- Dcache with read and write both high: treated as write.
- BUSY states:
  - `pmem_read`/`pmem_write` are driven from the latched op. Latched values are stable for the whole transaction, regardless of requester input changes.
  - The granted requester's resp equals `pmem_resp`, combinationally, in the same cycle. Its rdata equals `pmem_rdata`.
  - The other requester's resp stays 0. Its rdata holds its last delivered value (a registered copy is not required: 0 is acceptable).
  - On `pmem_resp` = 1: next state is IDLE.
- No back-to-back grant without passing through IDLE. This guarantees strobes drop for at least one cycle between transactions.
- Wait counters:
  - A counter increments in every cycle where its requester is asserted but it is not the granted owner in a BUSY state. This includes the IDLE cycle on which the request is first seen.
  - Saturates at all-ones. Never wraps.
- `pmem_resp` in IDLE: ignored, no resp forwarded.

## Timing
- Reset values: all outputs 0, counters 0, state IDLE. Reset is asynchronous; it asserts mid-transaction and immediately drops `pmem_read`/`pmem_write`.
- Arbitration latency: request seen in IDLE at cycle 0 gives strobe high at cycle 1.
- Completion: `pmem_resp` at cycle N gives requester resp at cycle N and strobes low at cycle N+1.
- Requesters must deassert in cycle N+1. The earliest next grant is therefore strobe high at N+2.
- Simultaneous requests from both caches in IDLE: exactly one is granted; the loser's counter increments every cycle until it is granted.
- A request arriving while BUSY is not lost: it is granted from the next IDLE cycle.

## Structure
- `lc3b_types` already holds `lc3b_word` and `lc3b_c_block`. Add `pmem_arb_state_t` (IDLE/I_BUSY/D_BUSY) there so benches can reference states.
- One natural sub-module, `sat_counter` (parameter `width`; ports `clk`, `rst_n`, `inc`, `count`), instantiated twice.
- Latched address/wdata/op use the codebase `register` module or equivalent flops with load = grant.

## Test plan
- Reset mid-transaction:
  - Stimulus: icache read granted, then `rst_n` low for 1 cycle before `pmem_resp`.
  - Required: `pmem_read` goes 0 immediately; state IDLE; counters 0; no resp emitted.
- Lone icache fill:
  - Stimulus: address 0x1236 at cycle 0; `pmem_resp` with rdata 0xDEAD_BEEF_… at cycle 5.
  - Required: `pmem_read` = 1 during cycles 1–5; `pmem_address` = 0x1230; `icache_pmem_resp` = 1 only at cycle 5 with that data; `dcache_pmem_resp` = 0 throughout; `icache_wait_count` = 1.
- Simultaneous first requests:
  - Stimulus: icache read 0x0100 and dcache write 0x2000 (wdata 0xA5…A5) both at cycle 0; memory responds 4 cycles after each strobe.
  - Required: dcache is served first (`pmem_write` = 1, address 0x2000); icache is served next; `icache_wait_count` = 6, `dcache_wait_count` = 1.
- Round-robin on repeated ties:
  - Stimulus: both caches request continuously for 4 transactions.
  - Required: grant order D, I, D, I.
- Input stability:
  - Stimulus: dcache changes address/wdata while D_BUSY.
  - Required: `pmem_address`/`pmem_wdata` unchanged until resp.
- Saturation:
  - Stimulus: `CNT_WIDTH` = 4; icache blocked for 20 cycles.
  - Required: `icache_wait_count` stops at 15.
